// File: rtl/mem_stage_pkg.sv
// ----------------------------------------------------------------------------
// mem_stage_pkg
//   Shared definitions for the SRAM-backed MEM stage:
//     state_e  - transfer FSM states (IDLE / ACCESS / DONE)
//     beats()  - number of narrow SRAM accesses per pipeline word
//     clog2()  - ceiling log2 usable in constant expressions
// ----------------------------------------------------------------------------
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

    function automatic int beats(input int data_w, input int sram_dw);
        return data_w / sram_dw;
    endfunction

endpackage

// File: rtl/sram_beat_seq.sv
// ----------------------------------------------------------------------------
// sram_beat_seq
//   Beat and wait-state counters for one SRAM transfer. Each beat lasts
//   WAIT_ST+1 cycles while run is high.
//   Ports:
//     clk       in   clock, rising edge
//     rst_n     in   asynchronous reset, active-low
//     start     in   clear both counters (transfer accepted)
//     run       in   transfer in progress (ACCESS state)
//     beat      out  current beat index, 0 = least significant slice
//     last_cyc  out  final cycle of the current beat
//     last_beat out  current beat is the final one
// ----------------------------------------------------------------------------
module sram_beat_seq
    import mem_stage_pkg::*;
#(
    parameter int BEATS   = 2,
    parameter int WAIT_ST = 1,
    localparam int BW     = (BEATS > 1) ? clog2(BEATS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          run,
    output logic [BW-1:0] beat,
    output logic          last_cyc,
    output logic          last_beat
);

    logic [3:0]    wait_q, wait_d;
    logic [BW-1:0] beat_q, beat_d;

    assign last_cyc  = run && (wait_q == 4'(WAIT_ST));
    assign last_beat = (beat_q == BW'(BEATS - 1));
    assign beat      = beat_q;

    always_comb begin
        wait_d = wait_q;
        beat_d = beat_q;
        if (start) begin
            wait_d = '0;
            beat_d = '0;
        end else if (run) begin
            if (last_cyc) begin
                wait_d = '0;
                beat_d = last_beat ? '0 : beat_q + 1'b1;
            end else begin
                wait_d = wait_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q <= '0;
            beat_q <= '0;
        end else begin
            wait_q <= wait_d;
            beat_q <= beat_d;
        end
    end

endmodule

// File: rtl/sram_mem_stage.sv
// ----------------------------------------------------------------------------
// sram_mem_stage
//   MEM stage that splits a DATA_W-bit load/store into DATA_W/SRAM_DW
//   sequential accesses on a narrow off-chip SRAM with WAIT_ST wait states
//   per beat. Ready low stalls the upstream pipeline until the transfer ends.
//   Optional feature macro: MEM_STAGE_RD_CACHE_EN adds a one-entry
//   write-through read cache; a load hit completes without an SRAM cycle.
//   Ports:
//     clk        in     clock, rising edge
//     rst        in     asynchronous reset, active-low
//     Mem_R_EN   in     load request (level, held until Ready)
//     Mem_W_EN   in     store request (level, held until Ready); wins over load
//     ALU_res    in     byte address
//     Val_Rm     in     store data
//     SRAM_data  inout  SRAM data bus, driven only during write beats
//     SRAM_addr  out    SRAM word address (registered)
//     SRAM_WE_N  out    SRAM write strobe, active-low (registered)
//     Ready      out    1 = stage not stalling
//     data_mem   out    load result (registered)
// ----------------------------------------------------------------------------
module sram_mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int SRAM_DW   = 16,
    parameter int SRAM_AW   = 18,
    parameter int BASE_ADDR = 1024,
    parameter int WAIT_ST   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               Mem_R_EN,
    input  logic               Mem_W_EN,
    input  logic [DATA_W-1:0]  ALU_res,
    input  logic [DATA_W-1:0]  Val_Rm,
    inout  wire  [SRAM_DW-1:0] SRAM_data,
    output logic [SRAM_AW-1:0] SRAM_addr,
    output logic               SRAM_WE_N,
    output logic               Ready,
    output logic [DATA_W-1:0]  data_mem
);

    localparam int BEATS = beats(DATA_W, SRAM_DW);
    localparam int BW    = (BEATS > 1) ? clog2(BEATS) : 1;
    localparam int SHIFT = clog2(DATA_W / 8);

    state_e state_q, state_d;

    logic               req, go, hit_ld;
    logic [DATA_W-1:0]  off, word, waddr_full;
    logic               unused_waddr_hi;

    logic [SRAM_AW-1:0] addr_q, addr_d;
    logic               we_n_q, we_n_d;
    logic               is_wr_q, is_wr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  rd_buf_q, rd_buf_d;
    logic [DATA_W-1:0]  data_mem_q, data_mem_d;

    logic [BW-1:0]      beat;
    logic               last_cyc, last_beat;

    assign req  = Mem_R_EN | Mem_W_EN;
    assign go   = req & ~hit_ld;

    // Word index relative to the SRAM window; the product is taken modulo
    // 2^SRAM_AW so out-of-window addresses wrap silently.
    assign off        = ALU_res - DATA_W'(BASE_ADDR);
    assign word       = off >> SHIFT;
    assign waddr_full = word * DATA_W'(BEATS);
    assign unused_waddr_hi = ^waddr_full[DATA_W-1:SRAM_AW];

    sram_beat_seq #(
        .BEATS   (BEATS),
        .WAIT_ST (WAIT_ST)
    ) u_beat_seq (
        .clk       (clk),
        .rst_n     (rst),
        .start     ((state_q == IDLE) && go),
        .run       (state_q == ACCESS),
        .beat      (beat),
        .last_cyc  (last_cyc),
        .last_beat (last_beat)
    );

    // FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // FSM: next state. A dropped request mid-transfer does not abort it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (go) state_d = ACCESS;
            ACCESS:  if (last_cyc && last_beat) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs. Ready falls combinationally on a request accepted in IDLE.
    always_comb begin
        Ready = (state_q == DONE) || ((state_q == IDLE) && !go);
    end

    // Store slice for the current beat goes on the bus only while WE_N is low.
    assign SRAM_data = !we_n_q ? wdata_q[int'(beat)*SRAM_DW +: SRAM_DW]
                               : {SRAM_DW{1'bz}};

`ifdef MEM_STAGE_RD_CACHE_EN
    logic              c_vld_q, c_vld_d;
    logic [DATA_W-1:0] c_tag_q, c_tag_d, c_data_q, c_data_d, tag_q, tag_d;

    assign hit_ld = (state_q == IDLE) && Mem_R_EN && !Mem_W_EN &&
                    c_vld_q && (c_tag_q == word);

    always_comb begin
        c_vld_d  = c_vld_q;
        c_tag_d  = c_tag_q;
        c_data_d = c_data_q;
        tag_d    = tag_q;
        if ((state_q == IDLE) && go) tag_d = word;
        if (state_q == DONE) begin
            if (!is_wr_q) begin
                // data_mem already holds the assembled word in DONE.
                c_vld_d  = 1'b1;
                c_tag_d  = tag_q;
                c_data_d = data_mem_q;
            end else if (c_vld_q && (c_tag_q == tag_q)) begin
                c_data_d = wdata_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) c_vld_q <= 1'b0;
        else      c_vld_q <= c_vld_d;
    end

    always_ff @(posedge clk) begin
        c_tag_q  <= c_tag_d;
        c_data_q <= c_data_d;
        tag_q    <= tag_d;
    end
`else
    assign hit_ld = 1'b0;
`endif

    // Datapath next-state
    always_comb begin
        addr_d     = addr_q;
        we_n_d     = 1'b1;
        is_wr_d    = is_wr_q;
        wdata_d    = wdata_q;
        rd_buf_d   = rd_buf_q;
        data_mem_d = data_mem_q;
        case (state_q)
            IDLE: begin
                if (go) begin
                    addr_d  = waddr_full[SRAM_AW-1:0];
                    we_n_d  = ~Mem_W_EN;
                    is_wr_d = Mem_W_EN;
                    wdata_d = Val_Rm;
                end
`ifdef MEM_STAGE_RD_CACHE_EN
                if (hit_ld) data_mem_d = c_data_q;
`endif
            end
            ACCESS: begin
                // Address and strobe both update on the beat boundary edge.
                we_n_d = ~is_wr_q | (last_cyc & last_beat);
                if (last_cyc && !last_beat) addr_d = addr_q + 1'b1;
                if (!is_wr_q && last_cyc) begin
                    rd_buf_d[int'(beat)*SRAM_DW +: SRAM_DW] = SRAM_data;
                    // data_mem changes only once the whole word is in.
                    if (last_beat) data_mem_d = rd_buf_d;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q     <= '0;
            we_n_q     <= 1'b1;
            is_wr_q    <= 1'b0;
            data_mem_q <= '0;
        end else begin
            addr_q     <= addr_d;
            we_n_q     <= we_n_d;
            is_wr_q    <= is_wr_d;
            data_mem_q <= data_mem_d;
        end
    end

    always_ff @(posedge clk) begin
        wdata_q  <= wdata_d;
        rd_buf_q <= rd_buf_d;
    end

    assign SRAM_addr = addr_q;
    assign SRAM_WE_N = we_n_q;
    assign data_mem  = data_mem_q;

endmodule

// File: tb/tb_sram_mem_stage.sv
module tb_sram_mem_stage;

    logic        clk;
    logic        rst;
    logic        Mem_R_EN, Mem_W_EN;
    logic [31:0] ALU_res, Val_Rm;
    wire  [15:0] sram_bus;
    logic [17:0] SRAM_addr;
    logic        SRAM_WE_N;
    logic        Ready;
    logic [31:0] data_mem;

    int checks   = 0;
    int failures = 0;

    logic        mem_init;
    logic [15:0] sram [0:15];
    logic [17:0] a1, a3;

    sram_mem_stage dut (
        .clk       (clk),
        .rst       (rst),
        .Mem_R_EN  (Mem_R_EN),
        .Mem_W_EN  (Mem_W_EN),
        .ALU_res   (ALU_res),
        .Val_Rm    (Val_Rm),
        .SRAM_data (sram_bus),
        .SRAM_addr (SRAM_addr),
        .SRAM_WE_N (SRAM_WE_N),
        .Ready     (Ready),
        .data_mem  (data_mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: 16 words, indexed by the low address bits.
    assign sram_bus = SRAM_WE_N ? sram[SRAM_addr[3:0]] : 16'hzzzz;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) sram[i] <= 16'hA000 + 16'(i);
        end else if (!SRAM_WE_N) begin
            sram[SRAM_addr[3:0]] <= sram_bus;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load: request in cycle 0, Ready expected back in cycle 5.
    task automatic do_load(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        Mem_R_EN = 1'b1;
        ALU_res  = adr;
        #1;
        chk({tag, "_rdy_c0"}, 32'(Ready), 32'd0);
        tick(); a1 = SRAM_addr;
        chk({tag, "_we_c1"}, 32'(SRAM_WE_N), 32'd1);
        tick();
        tick(); a3 = SRAM_addr;
        tick();
        chk({tag, "_rdy_c4"}, 32'(Ready), 32'd0);
        tick();
        chk({tag, "_rdy_c5"}, 32'(Ready), 32'd1);
        chk({tag, "_data"}, data_mem, exp);
        Mem_R_EN = 1'b0;
        tick();
    endtask

    task automatic do_store(input string tag, input logic [31:0] adr, input logic [31:0] val,
                            input logic also_rd);
        Mem_W_EN = 1'b1;
        Mem_R_EN = also_rd;
        ALU_res  = adr;
        Val_Rm   = val;
        #1;
        chk({tag, "_rdy_c0"}, 32'(Ready), 32'd0);
        repeat (5) tick();
        chk({tag, "_rdy_c5"}, 32'(Ready), 32'd1);
        chk({tag, "_we_c5"}, 32'(SRAM_WE_N), 32'd1);
        Mem_W_EN = 1'b0;
        Mem_R_EN = 1'b0;
        tick();
    endtask

    initial begin
        rst      = 1'b1;
        Mem_R_EN = 1'b0;
        Mem_W_EN = 1'b0;
        ALU_res  = 32'd0;
        Val_Rm   = 32'd0;
        mem_init = 1'b1;
        #2 rst = 1'b0;
        tick();
        tick();
        chk("rst_we_n", 32'(SRAM_WE_N), 32'd1);
        chk("rst_addr", 32'(SRAM_addr), 32'd0);
        chk("rst_data", data_mem, 32'd0);
        chk("rst_ready", 32'(Ready), 32'd1);
        rst      = 1'b1;
        mem_init = 1'b0;
        tick();

        // 1: store DEADBEEF at 1024, cycle by cycle
        Mem_W_EN = 1'b1;
        ALU_res  = 32'd1024;
        Val_Rm   = 32'hDEADBEEF;
        #1;
        chk("st_rdy_c0", 32'(Ready), 32'd0);
        tick();
        chk("st_we_c1", 32'(SRAM_WE_N), 32'd0);
        chk("st_addr_c1", 32'(SRAM_addr), 32'd0);
        chk("st_bus_c1", 32'(sram_bus), 32'h0000BEEF);
        tick();
        chk("st_we_c2", 32'(SRAM_WE_N), 32'd0);
        chk("st_addr_c2", 32'(SRAM_addr), 32'd0);
        tick();
        chk("st_we_c3", 32'(SRAM_WE_N), 32'd0);
        chk("st_addr_c3", 32'(SRAM_addr), 32'd1);
        chk("st_bus_c3", 32'(sram_bus), 32'h0000DEAD);
        tick();
        chk("st_rdy_c4", 32'(Ready), 32'd0);
        tick();
        chk("st_rdy_c5", 32'(Ready), 32'd1);
        chk("st_we_c5", 32'(SRAM_WE_N), 32'd1);
        Mem_W_EN = 1'b0;
        tick();
        chk("st_sram0", 32'(sram[0]), 32'h0000BEEF);
        chk("st_sram1", 32'(sram[1]), 32'h0000DEAD);

        // 2: load it back
        do_load("ld1024", 32'd1024, 32'hDEADBEEF);
        chk("ld1024_a1", 32'(a1), 32'd0);
        chk("ld1024_a3", 32'(a3), 32'd1);

        // 3: addressing, including wrap below the base
        do_load("ld1032", 32'd1032, 32'hA005A004);
        chk("ld1032_a1", 32'(a1), 32'd4);
        chk("ld1032_a3", 32'(a3), 32'd5);
        do_load("ld1020", 32'd1020, 32'hA00FA00E);
        chk("ld1020_a1", 32'(a1), 32'h3FFFE);
        chk("ld1020_a3", 32'(a3), 32'h3FFFF);

        // 4: both enables -> store, data_mem untouched
        do_store("both", 32'd1036, 32'h12345678, 1'b1);
        chk("both_data_keep", data_mem, 32'hA00FA00E);
        do_load("ld1036", 32'd1036, 32'h12345678);
        chk("ld1036_a1", 32'(a1), 32'd6);

        // 5: reset during beat 1 of a store
        Mem_W_EN = 1'b1;
        ALU_res  = 32'd1040;
        Val_Rm   = 32'hCAFEF00D;
        repeat (3) tick();
        chk("abort_addr_pre", 32'(SRAM_addr), 32'd9);
        chk("abort_we_pre", 32'(SRAM_WE_N), 32'd0);
        rst      = 1'b0;
        Mem_W_EN = 1'b0;
        #1;
        chk("abort_we", 32'(SRAM_WE_N), 32'd1);
        chk("abort_addr", 32'(SRAM_addr), 32'd0);
        chk("abort_ready", 32'(Ready), 32'd1);
        chk("abort_data", data_mem, 32'd0);
        chk("abort_bus_released", 32'(sram_bus), 32'h0000BEEF);
        tick();
        rst = 1'b1;
        tick();
        do_load("post_rst", 32'd1024, 32'hDEADBEEF);

`ifdef MEM_STAGE_RD_CACHE_EN
        // 6: cache hit, then write-through
        Mem_R_EN = 1'b1;
        ALU_res  = 32'd1024;
        #1;
        chk("hit_rdy", 32'(Ready), 32'd1);
        tick();
        chk("hit_addr", 32'(SRAM_addr), 32'd1);
        chk("hit_data", data_mem, 32'hDEADBEEF);
        Mem_R_EN = 1'b0;
        tick();
        do_store("st5", 32'd1024, 32'd5, 1'b0);
        Mem_R_EN = 1'b1;
        #1;
        chk("hit5_rdy", 32'(Ready), 32'd1);
        tick();
        chk("hit5_addr", 32'(SRAM_addr), 32'd1);
        chk("hit5_data", data_mem, 32'd5);
        Mem_R_EN = 1'b0;
        tick();
`else
        // 6: without the cache a repeat load goes to the SRAM again
        do_load("reld1024", 32'd1024, 32'hDEADBEEF);
        do_store("st5", 32'd1024, 32'd5, 1'b0);
        do_load("ld5", 32'd1024, 32'd5);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
